// File: rtl/g4_pkg.sv
// Shared parameters, walker state encoding and tuple field layout for the G4 chain walker.
package g4_pkg;

    localparam int IDX_W            = 11;
    localparam int TUPLE_W          = 104;
    localparam int ENTRY_W          = 171;
    localparam int HOPS_W           = 5;
    localparam int TABLE_ENTRY_SIZE = 29;
    localparam int MAX_HOPS         = 30;
    localparam logic [IDX_W-1:0] NULL_IDX = 11'h7FF;

    localparam int SRC_IP_LSB   = 0;
    localparam int DST_IP_LSB   = 32;
    localparam int SRC_PORT_LSB = 64;
    localparam int DST_PORT_LSB = 80;
    localparam int PROTO_LSB    = 96;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } walk_state_e;

    // Rebuilds the tuple from its named fields so the layout lives in one place.
    function automatic logic [TUPLE_W-1:0] pack_tuple(input logic [TUPLE_W-1:0] t);
        return {t[PROTO_LSB +: 8], t[DST_PORT_LSB +: 16], t[SRC_PORT_LSB +: 16],
                t[DST_IP_LSB +: 32], t[SRC_IP_LSB +: 32]};
    endfunction

endpackage

// File: rtl/g4_chain_walker.sv
// Hash-chain walker in front of one G4 table: walks next pointers, keeps the best ruleID,
// and shares the table port with single-entry updates. G4_EARLY_EXIT_EN stops on the first match.
module g4_chain_walker
    import g4_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_valid,
    output logic               pkt_ready,
    input  logic [TUPLE_W-1:0] pkt_tuple,
    input  logic [IDX_W-1:0]   pkt_head,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [IDX_W-1:0]   upd_index,
    input  logic [ENTRY_W-1:0] upd_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_hit,
    output logic [IDX_W-1:0]   res_rule_id,
    output logic [HOPS_W-1:0]  res_hops,
    output logic               res_err,
    output logic [IDX_W-1:0]   tbl_search_index,
    output logic [TUPLE_W-1:0] tbl_tuple,
    output logic               tbl_we,
    output logic [ENTRY_W-1:0] tbl_din,
    input  logic               tbl_match,
    input  logic [IDX_W-1:0]   tbl_rule_id,
    input  logic [IDX_W-1:0]   tbl_next_index
);

    walk_state_e        state_q, state_d;
    logic               active_q, active_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [IDX_W-1:0]   best_q, best_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic [HOPS_W-1:0]  hops_q, hops_d;
    logic               hit_q, hit_d;
    logic               err_q, err_d;
    logic [TUPLE_W-1:0] tuple_q, tuple_d;

    logic idle, done, upd_acc, pkt_acc;

    // active_q keeps both ready outputs low while reset is held and for the first cycle after.
    assign idle    = active_q & (state_q == ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign upd_acc = idle & upd_valid;
    assign pkt_acc = idle & ~upd_valid & pkt_valid;

    always_comb begin
        state_d  = state_q;
        active_d = 1'b1;
        cur_d    = cur_q;
        best_d   = best_q;
        addr_d   = addr_q;
        hops_d   = hops_q;
        hit_d    = hit_q;
        err_d    = err_q;
        tuple_d  = tuple_q;

        case (state_q)
            ST_IDLE: begin
                if (upd_acc) begin
                    addr_d = upd_index;
                end else if (pkt_acc) begin
                    tuple_d = pack_tuple(pkt_tuple);
                    cur_d   = pkt_head;
                    hops_d  = '0;
                    hit_d   = 1'b0;
                    best_d  = NULL_IDX;
                    err_d   = 1'b0;
                    state_d = (pkt_head == NULL_IDX) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                addr_d = cur_q;
                if (cur_q > IDX_W'(TABLE_ENTRY_SIZE)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                hops_d = hops_q + 1'b1;
`ifdef G4_EARLY_EXIT_EN
                if (tbl_match) begin
                    best_d  = tbl_rule_id;
                    hit_d   = 1'b1;
                    state_d = ST_DONE;
                end else
`else
                // Strict compare keeps the earliest entry when ruleIDs tie.
                if (tbl_match && (tbl_rule_id < best_q)) begin
                    best_d = tbl_rule_id;
                    hit_d  = 1'b1;
                end
`endif
                if (tbl_next_index == NULL_IDX) begin
                    state_d = ST_DONE;
                end else if (hops_d == HOPS_W'(MAX_HOPS)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cur_d   = tbl_next_index;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
            cur_q    <= '0;
            best_q   <= NULL_IDX;
            addr_q   <= '0;
            hops_q   <= '0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
            tuple_q  <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            cur_q    <= cur_d;
            best_q   <= best_d;
            addr_q   <= addr_d;
            hops_q   <= hops_d;
            hit_q    <= hit_d;
            err_q    <= err_d;
            tuple_q  <= tuple_d;
        end
    end

    assign pkt_ready = idle & ~upd_valid;
    assign upd_ready = idle;

    // addr_q already holds cur during WAIT, so the table sees a stable address for the read.
    assign tbl_search_index = upd_acc ? upd_index :
                              (state_q == ST_ISSUE) ? cur_q : addr_q;
    assign tbl_we    = upd_acc;
    assign tbl_din   = upd_acc ? upd_data : '0;
    assign tbl_tuple = tuple_q;

    assign res_valid   = done;
    assign res_hit     = done & hit_q;
    assign res_rule_id = (done & hit_q) ? best_q : '0;
    assign res_hops    = done ? hops_q : '0;
    assign res_err     = done & err_q;

endmodule

// File: tb/tb_g4_chain_walker.sv
// Self-checking bench for g4_chain_walker: behavioural table, directed vector table, random chains.
module tb_g4_chain_walker;
    import g4_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               pkt_valid, pkt_ready;
    logic [TUPLE_W-1:0] pkt_tuple;
    logic [IDX_W-1:0]   pkt_head;
    logic               upd_valid, upd_ready;
    logic [IDX_W-1:0]   upd_index;
    logic [ENTRY_W-1:0] upd_data;
    logic               res_valid, res_ready, res_hit, res_err;
    logic [IDX_W-1:0]   res_rule_id;
    logic [HOPS_W-1:0]  res_hops;
    logic [IDX_W-1:0]   tbl_search_index;
    logic [TUPLE_W-1:0] tbl_tuple;
    logic               tbl_we;
    logic [ENTRY_W-1:0] tbl_din;
    logic               tbl_match;
    logic [IDX_W-1:0]   tbl_rule_id, tbl_next_index;

    always #5 clk = ~clk;

    g4_chain_walker dut (
        .clk(clk), .rst_n(rst_n),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_tuple(pkt_tuple), .pkt_head(pkt_head),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index), .upd_data(upd_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_rule_id(res_rule_id),
        .res_hops(res_hops), .res_err(res_err),
        .tbl_search_index(tbl_search_index), .tbl_tuple(tbl_tuple), .tbl_we(tbl_we), .tbl_din(tbl_din),
        .tbl_match(tbl_match), .tbl_rule_id(tbl_rule_id), .tbl_next_index(tbl_next_index)
    );

    // Table memory: written only through the DUT write port, read data one cycle after the address.
    // Entry layout used by this bench: [22]=match, [21:11]=ruleID, [10:0]=next.
    logic             t_match [0:29];
    logic [IDX_W-1:0] t_rule  [0:29];
    logic [IDX_W-1:0] t_next  [0:29];

    always @(posedge clk) begin
        if (tbl_we && tbl_search_index <= 11'd29) begin
            t_match[tbl_search_index] <= tbl_din[22];
            t_rule[tbl_search_index]  <= tbl_din[21:11];
            t_next[tbl_search_index]  <= tbl_din[10:0];
        end
        if (tbl_search_index <= 11'd29) begin
            tbl_match      <= t_match[tbl_search_index];
            tbl_rule_id    <= t_rule[tbl_search_index];
            tbl_next_index <= t_next[tbl_search_index];
        end else begin
            tbl_match      <= 1'b0;
            tbl_rule_id    <= '0;
            tbl_next_index <= NULL_IDX;
        end
    end

    // Golden copy of what the bench intends the table to hold.
    bit g_match [30];
    int g_rule  [30];
    int g_next  [30];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference walk written straight from the lookup rules.
    task automatic model(input int head, output bit hit, output int rule, output int hops,
                         output bit err, output int lat);
        int best, cur;
        bit oor;
        best = 'h7FF; hit = 0; hops = 0; err = 0; oor = 0; cur = head;
        if (cur != 'h7FF) begin
            forever begin
                if (cur > 29) begin err = 1; oor = 1; break; end
                hops++;
`ifdef G4_EARLY_EXIT_EN
                if (g_match[cur]) begin best = g_rule[cur]; hit = 1; break; end
`else
                if (g_match[cur] && g_rule[cur] < best) begin best = g_rule[cur]; hit = 1; end
`endif
                if (g_next[cur] == 'h7FF) break;
                if (hops == 30) begin err = 1; break; end
                cur = g_next[cur];
            end
        end
        rule = hit ? best : 0;
        lat  = 1 + 2 * hops + (oor ? 1 : 0);
    endtask

    task automatic wr(input int idx, input bit m, input int rule, input int nxt);
        int t;
        upd_index = IDX_W'(idx);
        upd_data  = ENTRY_W'({m, rule[10:0], nxt[10:0]});
        upd_valid = 1'b1;
        t = 0;
        while (!upd_ready && t < 50) begin @(negedge clk); t++; end
        chk("wr_accept", 32'(upd_ready), 32'd1);
        @(negedge clk);
        upd_valid = 1'b0;
        if (idx < 30) begin g_match[idx] = m; g_rule[idx] = rule; g_next[idx] = nxt; end
    endtask

    // Called one negedge after the accepting posedge; checks latency, fields, hold stability.
    task automatic wait_result(input string tag, input logic [TUPLE_W-1:0] tup, input bit e_hit,
                               input int e_rule, input int e_hops, input bit e_err,
                               input int e_lat, input int hold);
        int lat;
        lat = 1;
        while (!res_valid && lat < 200) begin @(negedge clk); lat++; end
        chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
        chk({tag, ".hit"}, 32'(res_hit), 32'(e_hit));
        chk({tag, ".rule"}, 32'(res_rule_id), 32'(e_rule));
        chk({tag, ".hops"}, 32'(res_hops), 32'(e_hops));
        chk({tag, ".err"}, 32'(res_err), 32'(e_err));
        chk({tag, ".tuple"}, 32'(tbl_tuple == tup), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold"}, 32'({res_valid, pkt_ready, res_hit, res_err, res_hops, res_rule_id}),
                32'({1'b1, 1'b0, e_hit, e_err, 5'(e_hops), 11'(e_rule)}));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic lookup(input string tag, input int head, input bit e_hit, input int e_rule,
                          input int e_hops, input bit e_err, input int e_lat, input int hold);
        int t;
        logic [TUPLE_W-1:0] tup;
        tup = TUPLE_W'({$urandom, $urandom, $urandom, $urandom});
        pkt_tuple = tup;
        pkt_head  = IDX_W'(head);
        pkt_valid = 1'b1;
        #1;
        t = 0;
        while (!pkt_ready && t < 50) begin @(negedge clk); #1; t++; end
        chk({tag, ".accept"}, 32'(pkt_ready), 32'd1);
        @(negedge clk);
        pkt_valid = 1'b0;
        wait_result(tag, tup, e_hit, e_rule, e_hops, e_err, e_lat, hold);
    endtask

    task automatic lookup_model(input string tag, input int head, input int hold);
        bit h, e; int r, hp, l;
        model(head, h, r, hp, e, l);
        lookup(tag, head, h, r, hp, e, l, hold);
    endtask

    typedef struct {
        int head;
        bit hit;
        int rule;
        int hops;
        bit err;
        int lat;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [TUPLE_W-1:0] tup;
        int t, nxt, sel;

        rst_n = 1'b0; pkt_valid = 0; pkt_tuple = '0; pkt_head = '0;
        upd_valid = 0; upd_index = '0; upd_data = '0; res_ready = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.pkt_ready", 32'(pkt_ready), 0);
        chk("rst.upd_ready", 32'(upd_ready), 0);
        chk("rst.res", 32'({res_valid, res_hit, res_err, res_hops, res_rule_id}), 0);
        chk("rst.tbl", 32'({tbl_we, tbl_search_index, 32'(|tbl_tuple), 32'(|tbl_din)}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) wr(i, 0, 0, 'h7FF);
        wr(3, 0, 0, 7);   wr(7, 1, 12, 'h7FF);
        wr(0, 1, 40, 1);  wr(1, 0, 0, 2);  wr(2, 1, 9, 'h7FF);
        wr(5, 0, 0, 6);   wr(6, 0, 0, 5);
        wr(10, 1, 20, 11); wr(11, 1, 20, 'h7FF);
        wr(12, 1, 3, 40);

        vt[0] = '{3, 1, 12, 2, 0, 5};
`ifdef G4_EARLY_EXIT_EN
        vt[1] = '{0, 1, 40, 1, 0, 3};
        vt[5] = '{12, 1, 3, 1, 0, 3};
        vt[6] = '{10, 1, 20, 1, 0, 3};
`else
        vt[1] = '{0, 1, 9, 3, 0, 7};
        vt[5] = '{12, 1, 3, 1, 1, 4};
        vt[6] = '{10, 1, 20, 2, 0, 5};
`endif
        vt[2] = '{'h7FF, 0, 0, 0, 0, 1};
        vt[3] = '{5, 0, 0, 30, 1, 61};
        vt[4] = '{31, 0, 0, 0, 1, 2};
        vt[7] = '{7, 1, 12, 1, 0, 3};
        for (int i = 0; i < 8; i++)
            lookup($sformatf("vec%0d", i), vt[i].head, vt[i].hit, vt[i].rule, vt[i].hops,
                   vt[i].err, vt[i].lat, 0);

        // Update and lookup arrive together: write wins, lookup follows and sees the new entry.
        tup = TUPLE_W'({$urandom, $urandom, $urandom, $urandom});
        pkt_tuple = tup; pkt_head = 11'd20; pkt_valid = 1'b1;
        upd_index = 11'd20; upd_data = ENTRY_W'({1'b1, 11'd5, 11'h7FF}); upd_valid = 1'b1;
        #1;
        chk("coll.we", 32'({tbl_we, tbl_search_index}), 32'({1'b1, 11'd20}));
        chk("coll.din", 32'(tbl_din[22:0]), 32'({1'b1, 11'd5, 11'h7FF}));
        chk("coll.pkt_ready", 32'(pkt_ready), 0);
        @(negedge clk);
        upd_valid = 1'b0;
        g_match[20] = 1; g_rule[20] = 5; g_next[20] = 'h7FF;
        #1;
        chk("coll.we_off", 32'(tbl_we), 0);
        chk("coll.pkt_ready2", 32'(pkt_ready), 1);
        @(negedge clk);
        pkt_valid = 1'b0;
        wait_result("coll", tup, 1, 5, 1, 0, 3, 0);

        lookup("hold", 3, 1, 12, 2, 0, 5, 10);

        // Reset during a long walk returns everything to zero.
        pkt_head = 11'd5; pkt_valid = 1'b1;
        #1;
        t = 0;
        while (!pkt_ready && t < 50) begin @(negedge clk); #1; t++; end
        @(negedge clk);
        pkt_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.res", 32'({res_valid, res_hit, res_err, res_hops, res_rule_id}), 0);
        chk("midrst.ready", 32'({pkt_ready, upd_ready, tbl_we}), 0);
        chk("midrst.tbl", 32'({tbl_search_index, 32'(|tbl_tuple)}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        lookup_model("postrst", 0, 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 30; i++) begin
                sel = $urandom_range(0, 9);
                if (sel < 3)       nxt = 'h7FF;
                else if (sel == 3) nxt = $urandom_range(30, 40);
                else               nxt = $urandom_range(0, 29);
                wr(i, 1'($urandom_range(0, 1)), $urandom_range(0, 63), nxt);
            end
            for (int k = 0; k < 10; k++) begin
                sel = $urandom_range(0, 9);
                if (sel == 0)      lookup_model($sformatf("rnd%0d_%0d", r, k), 'h7FF, $urandom_range(0, 3));
                else if (sel == 1) lookup_model($sformatf("rnd%0d_%0d", r, k), $urandom_range(30, 60), $urandom_range(0, 3));
                else               lookup_model($sformatf("rnd%0d_%0d", r, k), $urandom_range(0, 29), $urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
